// File: rtl/rand_pkg.sv
// Shared types, constants and the range-to-mask helper for the random-number service.
package rand_pkg;

    typedef enum logic [1:0] {IDLE, SAMPLE, RESP} state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;  // bits 15,13,12,10
    localparam logic [15:0] DEFAULT_SEED = 16'hDEAD;

    // Smear the msb of (range-1) downward; range 0 wraps to 0xFFFF, range 1 gives 0.
    function automatic logic [15:0] range_mask(input logic [15:0] range);
        logic [15:0] m;
        m = range - 16'd1;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at/after ptr.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] gidx
);

    logic [IW-1:0] cidx [N];

    for (genvar k = 0; k < N; k++) begin : g_cand
        logic [IW:0] sum;
        assign sum     = {1'b0, ptr} + (IW+1)'(k);
        assign cidx[k] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
    end

    // Walk candidates from farthest to nearest so the nearest set request wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cidx[k]]) begin
                grant          = '0;
                grant[cidx[k]] = 1'b1;
                gidx           = cidx[k];
            end
        end
    end

endmodule

// File: rtl/rand_server.sv
// Shared LFSR random service: round-robin grant, masked rejection sampling into [0, range),
// registered one-hot response strobe.
module rand_server
    import rand_pkg::*;
#(
    parameter int          N_REQ     = 4,
    parameter logic [15:0] SEED      = DEFAULT_SEED,
    parameter int          MAX_TRIES = 8
) (
    input  logic               sys_clock,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*16-1:0] req_range,
    input  logic               seed_we,
    input  logic [15:0]        seed_data,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [15:0]        rsp_data,
    output logic               busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    state_t        state, state_nx;
    logic [15:0]   lfsr;
    logic [PW-1:0] rr_ptr, idx, gidx;
    logic [N_REQ-1:0] grant, idx_oh;
    logic [15:0]   rng, mask, samp, win_range;
    logic [TW-1:0] tries;
    logic          accept, last_try;

    rr_arbiter #(.N(N_REQ), .IW(PW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .gidx  (gidx)
    );

    assign win_range = req_range[16*gidx +: 16];
    assign samp      = lfsr & mask;
    assign accept    = (rng == 16'd0) || (samp < rng);
    assign last_try  = (tries == TW'(MAX_TRIES - 1));
    assign idx_oh    = N_REQ'(1) << idx;
    assign busy      = (state != IDLE);

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (|grant) state_nx = SAMPLE;
            SAMPLE:  if (accept || last_try) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Reseed wins over the free-running step; a zero seed would lock the LFSR.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n)     lfsr <= SEED;
        else if (seed_we) lfsr <= (seed_data == 16'd0) ? SEED : seed_data;
        else              lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= '0;
            idx       <= '0;
            rng       <= '0;
            mask      <= '0;
            tries     <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            unique case (state)
                IDLE: if (|grant) begin
                    idx   <= gidx;
                    rng   <= win_range;
                    mask  <= range_mask(win_range);
                    tries <= '0;
                end
                SAMPLE: begin
                    if (accept) begin
                        rsp_data  <= samp;
                        rsp_valid <= idx_oh;
                    end else if (last_try) begin
                        // mask < 2*range, so one subtraction always lands in range
                        rsp_data  <= samp - rng;
                        rsp_valid <= idx_oh;
                    end else begin
                        tries <= tries + TW'(1);
                    end
                end
                RESP:    rr_ptr <= (idx == PW'(N_REQ - 1)) ? '0 : idx + PW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rand_server.sv
// Directed bench for rand_server: stimulus pushes expected responses, a negedge monitor checks them.
module tb_rand_server;
    import rand_pkg::*;

    typedef struct {
        int          idx;
        logic [15:0] rng;
        logic        chk;
        logic [15:0] data;
    } exp_t;

    logic        sys_clock = 1'b0;
    logic        reset_n   = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_range = '0;
    logic        seed_we   = 1'b0;
    logic [15:0] seed_data = '0;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        busy;

    logic [3:0]  req1      = '0;
    logic [63:0] range1    = '0;
    logic        seed_we1  = 1'b0;
    logic [15:0] seed_data1 = '0;
    logic [3:0]  rsp_valid1;
    logic [15:0] rsp_data1;
    logic        busy1;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [9:0]  seen = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 sys_clock = ~sys_clock;

    rand_server u_dut (
        .sys_clock (sys_clock), .reset_n (reset_n),
        .req_valid (req_valid), .req_range (req_range),
        .seed_we   (seed_we),   .seed_data (seed_data),
        .rsp_valid (rsp_valid), .rsp_data  (rsp_data), .busy (busy)
    );

    rand_server #(.MAX_TRIES(1)) u_dut1 (
        .sys_clock (sys_clock), .reset_n (reset_n),
        .req_valid (req1),      .req_range (range1),
        .seed_we   (seed_we1),  .seed_data (seed_data1),
        .rsp_valid (rsp_valid1), .rsp_data (rsp_data1), .busy (busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input logic [15:0] rng, input logic chk, input logic [15:0] data);
        exp_t e;
        e.idx = idx; e.rng = rng; e.chk = chk; e.data = data;
        sb.push_back(e);
    endtask

    task automatic wait_rsp(input logic [3:0] msk, output int lat);
        lat = 0;
        do begin
            @(negedge sys_clock);
            lat++;
        end while ((rsp_valid & msk) == 4'd0 && lat < 40);
        if ((rsp_valid & msk) == 4'd0) begin
            n_cmp++; n_err++;
            $display("FAIL wait_rsp: no strobe on mask %b within 40 cycles", msk);
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clock);
        reset_n = 1'b0; req_valid = '0; seed_we = 1'b0; req1 = '0; seed_we1 = 1'b0;
        sb.delete();
        repeat (2) @(negedge sys_clock);
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor
    always @(negedge sys_clock) begin
        if (reset_n) begin
            check("onehot0", 32'($onehot0(rsp_valid)), 32'd1);
            check("busy_vs_state", 32'(busy), 32'(u_dut.state != IDLE));
            if (rsp_valid != 4'd0) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_rsp: got rsp_valid=%b, expected no response", rsp_valid);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_idx", 32'(rsp_valid), 32'(4'd1 << mon_e.idx));
                    if (mon_e.rng != 16'd0)
                        check("rsp_lt_range", 32'(rsp_data < mon_e.rng), 32'd1);
                    if (mon_e.chk)
                        check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
                    if (mon_e.rng == 16'd10 && rsp_data < 16'd10)
                        seen[int'(rsp_data)] = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        // 1: first response after reset is the first LFSR step from 0xDEAD
        repeat (3) @(negedge sys_clock);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        push(0, 16'd0, 1'b1, 16'hBD5B);
        req_range = '0;
        req_valid = 4'b0001;
        reset_n   = 1'b1;
        wait_rsp(4'b0001, lat);
        check("t1_latency", 32'(lat), 32'd2);
        req_valid = '0;

        // 2: range 1 always yields 0; range 10 stays below 10 and covers 0..9
        do_reset();
        req_range[15:0] = 16'd1;
        for (int k = 0; k < 100; k++) begin
            push(0, 16'd1, 1'b1, 16'd0);
            req_valid = 4'b0001;
            wait_rsp(4'b0001, lat);
        end
        req_valid = '0;
        repeat (2) @(negedge sys_clock);
        req_range[15:0] = 16'd10;
        for (int k = 0; k < 1000; k++) begin
            push(0, 16'd10, 1'b0, 16'd0);
            req_valid = 4'b0001;
            wait_rsp(4'b0001, lat);
        end
        req_valid = '0;
        check("t2_all_seen", 32'(seen), 32'h3FF);

        // 3: all requesting, full range -> rotating order, 3-cycle spacing
        do_reset();
        req_range = '0;
        for (int k = 0; k < 8; k++) push(k % 4, 16'd0, 1'b0, 16'd0);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_rsp(4'b1111, lat);
            if (k > 0) check("t3_gap", 32'(lat), 32'd3);
            check("t3_order", 32'(rsp_valid), 32'(4'd1 << (k % 4)));
        end
        req_valid = '0;

        // 4: zero seed substitutes 0xDEAD; seed 1 steps 1,2,4; range latched at grant
        do_reset();
        push(0, 16'd0, 1'b1, 16'hDEAD);
        seed_we = 1'b1; seed_data = 16'h0000; req_valid = 4'b0001; req_range = '0;
        @(negedge sys_clock);
        seed_we = 1'b0;
        wait_rsp(4'b0001, lat);
        req_valid = '0;
        repeat (2) @(negedge sys_clock);
        seed_we = 1'b1; seed_data = 16'h0001;
        @(negedge sys_clock);
        seed_we = 1'b0;
        check("t4_lfsr0", 32'(u_dut.lfsr), 32'h0001);
        @(negedge sys_clock);
        check("t4_lfsr1", 32'(u_dut.lfsr), 32'h0002);
        @(negedge sys_clock);
        check("t4_lfsr2", 32'(u_dut.lfsr), 32'h0004);
        seed_we = 1'b1; seed_data = 16'h0000;
        @(negedge sys_clock);
        seed_we = 1'b0;
        check("t4_zero_seed", 32'(u_dut.lfsr), 32'hDEAD);
        // 0xDEAD & 0xF = 13 < 16; the range change after grant must not matter
        push(1, 16'd16, 1'b1, 16'd13);
        seed_we = 1'b1; seed_data = 16'h0000; req_valid = 4'b0010; req_range[31:16] = 16'd16;
        @(negedge sys_clock);
        seed_we = 1'b0; req_range[31:16] = 16'd0;
        wait_rsp(4'b0010, lat);
        req_valid = '0;

        // 5: MAX_TRIES=1 fallback: sample 0xC, range 9 -> 12-9 = 3
        @(negedge sys_clock);
        req1 = 4'b0001; range1[15:0] = 16'd9; seed_we1 = 1'b1; seed_data1 = 16'h000C;
        lat = 0;
        do begin
            @(negedge sys_clock);
            seed_we1 = 1'b0;
            lat++;
        end while (rsp_valid1[0] == 1'b0 && lat < 40);
        check("t5_latency", 32'(lat), 32'd2);
        check("t5_data", 32'(rsp_data1), 32'd3);
        req1 = '0;

        // 6: reset during SAMPLE cancels the strobe and restores reset state
        do_reset();
        push(2, 16'd0, 1'b0, 16'd0);
        req_valid = 4'b0100;
        wait_rsp(4'b0100, lat);
        req_valid = '0;
        repeat (2) @(negedge sys_clock);
        check("t6_ptr_before", 32'(u_dut.rr_ptr), 32'd3);
        req_valid = 4'b0001;
        @(negedge sys_clock);
        check("t6_busy_in_sample", 32'(busy), 32'd1);
        reset_n = 1'b0;
        req_valid = '0;
        #1;
        check("t6_rst_valid", 32'(rsp_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        repeat (3) begin
            @(negedge sys_clock);
            check("t6_rst_hold_valid", 32'(rsp_valid), 32'd0);
        end
        reset_n = 1'b1;
        #1;
        check("t6_lfsr_seed", 32'(u_dut.lfsr), 32'hDEAD);
        check("t6_ptr_reset", 32'(u_dut.rr_ptr), 32'd0);
        @(negedge sys_clock);
        check("t6_lfsr_step", 32'(u_dut.lfsr), 32'hBD5B);
        repeat (4) @(negedge sys_clock);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
